// File: rtl/ra_builder.sv
// Region Array builder: one control word plus object-list pointers per tile, written row-major into VRAM.
// First word is presented 2 cycles after start; vram_wait holds the presented word, otherwise writes run back-to-back.
module ra_builder (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] REGION_BASE,
   input  logic [31:0] OL_BASE,
   input  logic [31:0] FPU_PARAM_CFG,
   input  logic [31:0] TA_ALLOC_CTRL,
   input  logic [5:0]  tiles_x_m1,
   input  logic [5:0]  tiles_y_m1,
   input  logic        zclear,
   input  logic        flush,
   input  logic        vram_wait,
   output logic        ra_vram_wr,
   output logic [23:0] ra_vram_addr,
   output logic [31:0] ra_vram_dout,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, SETUP, WRITE, DONE} state_t;

   // opb index order matches the entry word order: o, om, t, tm, pt
   typedef struct packed {
      logic [23:0]     region_base;
      logic [23:0]     ol_base;
      logic            v2;
      logic [4:0][1:0] opb;
      logic [5:0]      tx_m1;
      logic [5:0]      ty_m1;
      logic            zclear;
      logic            flush;
   } cfg_t;

   state_t           state_q, state_d;
   cfg_t             cfg_q, cfg_d;
   logic [5:0]       x_q, x_d, y_q, y_d;
   logic [2:0]       widx_q, widx_d;
   logic [23:0]      addr_q, addr_d;
   logic [4:0][23:0] ptr_q, ptr_d;

   logic [12:0]      ntiles;
   logic [4:0]       en;
   logic [4:0][23:0] alloc, base, step;
   logic [4:0][31:0] ptr_word;
   logic             last_word, last_tile;
   logic [31:0]      ctrl_word, word;

   logic unused_in;
   assign unused_in = ^{REGION_BASE[31:24], OL_BASE[31:24], FPU_PARAM_CFG[31:22],
                        FPU_PARAM_CFG[20:0], TA_ALLOC_CTRL[31:18], TA_ALLOC_CTRL[15:14],
                        TA_ALLOC_CTRL[11:10], TA_ALLOC_CTRL[7:6], TA_ALLOC_CTRL[3:2]};

   // List layout derived from the latched configuration; consumed in SETUP
   always_comb begin : layout_calc
      ntiles = (13'(cfg_q.tx_m1) + 13'd1) * (13'(cfg_q.ty_m1) + 13'd1);
      for (int k = 0; k < 4; k++) begin
         en[k] = (cfg_q.opb[k] != 2'd0);
      end
      en[4] = (cfg_q.opb[4] != 2'd0) & cfg_q.v2;
      for (int k = 0; k < 5; k++) begin
         step[k]  = 24'd16 << cfg_q.opb[k];
         alloc[k] = en[k] ? ({11'd0, ntiles} << (3'd4 + {1'b0, cfg_q.opb[k]})) : 24'd0;
      end
      base[0] = cfg_q.ol_base;
      base[1] = cfg_q.ol_base + alloc[0];
      base[2] = cfg_q.ol_base + alloc[0] + alloc[1];
      base[3] = cfg_q.ol_base + alloc[0] + alloc[1] + alloc[2];
      base[4] = cfg_q.ol_base + alloc[0] + alloc[1] + alloc[2] + alloc[3];
   end

   always_comb begin : word_sel
      for (int k = 0; k < 5; k++) begin
         ptr_word[k] = en[k] ? {8'h00, ptr_q[k]} : 32'h8000_0000;
      end
      last_tile = (x_q == cfg_q.tx_m1) && (y_q == cfg_q.ty_m1);
      last_word = (widx_q == (cfg_q.v2 ? 3'd5 : 3'd4));
      ctrl_word = {last_tile, cfg_q.zclear, 1'b0, cfg_q.flush, 14'd0, y_q, x_q, 2'b00};
      case (widx_q)
         3'd1:    word = ptr_word[0];
         3'd2:    word = ptr_word[1];
         3'd3:    word = ptr_word[2];
         3'd4:    word = ptr_word[3];
         3'd5:    word = ptr_word[4];
         default: word = ctrl_word;
      endcase
   end

   always_comb begin : next_state
      state_d = state_q;
      cfg_d   = cfg_q;
      x_d     = x_q;
      y_d     = y_q;
      widx_d  = widx_q;
      addr_d  = addr_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               cfg_d.region_base = REGION_BASE[23:0];
               cfg_d.ol_base     = OL_BASE[23:0];
               cfg_d.v2          = FPU_PARAM_CFG[21];
               cfg_d.opb[0]      = TA_ALLOC_CTRL[1:0];
               cfg_d.opb[1]      = TA_ALLOC_CTRL[5:4];
               cfg_d.opb[2]      = TA_ALLOC_CTRL[9:8];
               cfg_d.opb[3]      = TA_ALLOC_CTRL[13:12];
               cfg_d.opb[4]      = TA_ALLOC_CTRL[17:16];
               cfg_d.tx_m1       = tiles_x_m1;
               cfg_d.ty_m1       = tiles_y_m1;
               cfg_d.zclear      = zclear;
               cfg_d.flush       = flush;
               state_d           = SETUP;
            end
         end
         SETUP: begin
            ptr_d   = base;
            addr_d  = cfg_q.region_base;
            x_d     = 6'd0;
            y_d     = 6'd0;
            widx_d  = 3'd0;
            state_d = WRITE;
         end
         WRITE: begin
            if (!vram_wait) begin
               addr_d = addr_q + 24'd4;
               if (last_word) begin
                  widx_d = 3'd0;
                  for (int k = 0; k < 5; k++) begin
                     if (en[k]) ptr_d[k] = ptr_q[k] + step[k];
                  end
                  if (last_tile) begin
                     state_d = DONE;
                  end else if (x_q == cfg_q.tx_m1) begin
                     x_d = 6'd0;
                     y_d = y_q + 6'd1;
                  end else begin
                     x_d = x_q + 6'd1;
                  end
               end else begin
                  widx_d = widx_q + 3'd1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cfg_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         widx_q  <= '0;
         addr_q  <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         cfg_q   <= cfg_d;
         x_q     <= x_d;
         y_q     <= y_d;
         widx_q  <= widx_d;
         addr_q  <= addr_d;
         ptr_q   <= ptr_d;
      end
   end

   // Outputs decode straight from flops so a reset clears them without waiting for a clock
   assign ra_vram_wr   = (state_q == WRITE);
   assign ra_vram_addr = ra_vram_wr ? addr_q : 24'd0;
   assign ra_vram_dout = ra_vram_wr ? word : 32'd0;
   assign busy         = (state_q == SETUP) || (state_q == WRITE);
   assign done         = (state_q == DONE);

endmodule

// File: tb/tb_ra_builder.sv
// Directed self-checking bench for ra_builder: accepted writes are collected at negedge and compared per scenario.
module tb_ra_builder;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic [31:0] REGION_BASE, OL_BASE, FPU_PARAM_CFG, TA_ALLOC_CTRL;
   logic [5:0]  tiles_x_m1, tiles_y_m1;
   logic        zclear, flush, vram_wait;
   logic        ra_vram_wr;
   logic [23:0] ra_vram_addr;
   logic [31:0] ra_vram_dout;
   logic        busy, done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = -1;
   logic [23:0] got_addr[$];
   logic [31:0] got_dat[$];

   ra_builder dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .REGION_BASE(REGION_BASE), .OL_BASE(OL_BASE),
      .FPU_PARAM_CFG(FPU_PARAM_CFG), .TA_ALLOC_CTRL(TA_ALLOC_CTRL),
      .tiles_x_m1(tiles_x_m1), .tiles_y_m1(tiles_y_m1),
      .zclear(zclear), .flush(flush), .vram_wait(vram_wait),
      .ra_vram_wr(ra_vram_wr), .ra_vram_addr(ra_vram_addr), .ra_vram_dout(ra_vram_dout),
      .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   initial begin
      forever begin
         @(posedge clock);
         cyc++;
      end
   end

   initial begin
      forever begin
         @(negedge clock);
         if (ra_vram_wr && !vram_wait) begin
            got_addr.push_back(ra_vram_addr);
            got_dat.push_back(ra_vram_dout);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic set_cfg(input logic [31:0] rb, input logic [31:0] ob, input logic [31:0] fpu,
                          input logic [31:0] ta, input logic [5:0] tx, input logic [5:0] ty,
                          input logic zc, input logic fl);
      REGION_BASE   = rb;
      OL_BASE       = ob;
      FPU_PARAM_CFG = fpu;
      TA_ALLOC_CTRL = ta;
      tiles_x_m1    = tx;
      tiles_y_m1    = ty;
      zclear        = zc;
      flush         = fl;
   endtask

   // c0 is the cycle in which start is high; the edge ending it samples start
   task automatic pulse_start(output int c0);
      @(posedge clock);
      #1;
      start = 1'b1;
      c0 = cyc;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int base_cnt, input int limit);
      int n;
      n = 0;
      while (done_cnt == base_cnt && n < limit) begin
         @(negedge clock);
         n++;
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++; if (ra_vram_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", ra_vram_wr); end
      checks++; if (ra_vram_addr !== 24'd0) begin errors++; $display("FAIL reset_addr got %h want 0", ra_vram_addr); end
      checks++; if (ra_vram_dout !== 32'd0) begin errors++; $display("FAIL reset_dout got %h want 0", ra_vram_dout); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      @(negedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_single_v2;
      int c0, b;
      logic [31:0] exp_d [6];
      exp_d = '{32'h8000_0000, 32'h0020_0000, 32'h0020_0020, 32'h0020_0040, 32'h0020_0060, 32'h0020_0080};
      set_cfg(32'h0010_0000, 32'h0020_0000, 32'h0020_0000, 32'h0001_1111, 6'd0, 6'd0, 1'b0, 1'b0);
      got_addr.delete(); got_dat.delete();
      b = done_cnt;
      pulse_start(c0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL v2_busy_setup got %b want 1", busy); end
      checks++; if (ra_vram_wr !== 1'b0) begin errors++; $display("FAIL v2_wr_setup got %b want 0", ra_vram_wr); end
      wait_done(b, 50);
      checks++; if (done_cyc - c0 != 8) begin errors++; $display("FAIL v2_latency got %0d want 8", done_cyc - c0); end
      checks++; if (got_dat.size() != 6) begin errors++; $display("FAIL v2_count got %0d want 6", got_dat.size()); end
      for (int i = 0; i < 6 && i < got_dat.size(); i++) begin
         checks++;
         if (got_dat[i] !== exp_d[i] || got_addr[i] !== 24'h10_0000 + 24'(4 * i)) begin
            errors++;
            $display("FAIL v2_word%0d got %h@%h want %h@%h", i, got_dat[i], got_addr[i], exp_d[i], 24'h10_0000 + 24'(4 * i));
         end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL v2_busy_done got %b want 0", busy); end
      repeat (2) @(posedge clock);
      #1;
      checks++; if (done_cnt - b != 1) begin errors++; $display("FAIL v2_done_pulse got %0d want 1", done_cnt - b); end
   endtask

   task automatic test_grid_v1;
      int c0, b, t;
      logic [31:0] exp_d;
      set_cfg(32'h0001_0000, 32'h0030_0000, 32'h0000_0000, 32'h0000_0203, 6'd1, 6'd1, 1'b0, 1'b0);
      got_addr.delete(); got_dat.delete();
      b = done_cnt;
      pulse_start(c0);
      wait_done(b, 60);
      checks++; if (done_cyc - c0 != 22) begin errors++; $display("FAIL grid_latency got %0d want 22", done_cyc - c0); end
      checks++; if (got_dat.size() != 20) begin errors++; $display("FAIL grid_count got %0d want 20", got_dat.size()); end
      for (int i = 0; i < 20 && i < got_dat.size(); i++) begin
         t = i / 5;
         case (i % 5)
            0:       exp_d = ((t == 3) ? 32'h8000_0000 : 32'h0) | 32'((t / 2) << 8) | 32'((t % 2) << 2);
            1:       exp_d = 32'h0030_0000 + 32'(t * 32'h80);
            3:       exp_d = 32'h0030_0200 + 32'(t * 32'h40);
            default: exp_d = 32'h8000_0000;
         endcase
         checks++;
         if (got_dat[i] !== exp_d || got_addr[i] !== 24'h01_0000 + 24'(4 * i)) begin
            errors++;
            $display("FAIL grid_word%0d got %h@%h want %h@%h", i, got_dat[i], got_addr[i], exp_d, 24'h01_0000 + 24'(4 * i));
         end
      end
      repeat (2) @(posedge clock);
   endtask

   task automatic test_ctrl_bits;
      int c0, b;
      set_cfg(32'h00FF_FF00, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 6'd4, 6'd3, 1'b1, 1'b1);
      got_addr.delete(); got_dat.delete();
      b = done_cnt;
      pulse_start(c0);
      wait_done(b, 200);
      checks++; if (done_cyc - c0 != 102) begin errors++; $display("FAIL ctrl_latency got %0d want 102", done_cyc - c0); end
      checks++; if (got_dat.size() != 100) begin errors++; $display("FAIL ctrl_count got %0d want 100", got_dat.size()); end
      if (got_dat.size() == 100) begin
         checks++; if (got_dat[0] !== 32'h5000_0000) begin errors++; $display("FAIL ctrl_tile0 got %h want 50000000", got_dat[0]); end
         checks++; if (got_dat[90] !== 32'h5000_030C) begin errors++; $display("FAIL ctrl_tile33 got %h want 5000030c", got_dat[90]); end
         checks++; if (got_dat[91] !== 32'h8000_0000) begin errors++; $display("FAIL ctrl_disabled got %h want 80000000", got_dat[91]); end
         checks++; if (got_dat[95] !== 32'hD000_0310) begin errors++; $display("FAIL ctrl_last got %h want d0000310", got_dat[95]); end
         checks++; if (got_addr[99] !== 24'h00_008C) begin errors++; $display("FAIL ctrl_addr_wrap got %h want 00008c", got_addr[99]); end
      end
      repeat (2) @(posedge clock);
   endtask

   task automatic test_stall;
      int c0, b;
      logic [31:0] exp_d [6];
      exp_d = '{32'h8000_0000, 32'h0020_0000, 32'h0020_0020, 32'h0020_0040, 32'h0020_0060, 32'h0020_0080};
      set_cfg(32'h0010_0000, 32'h0020_0000, 32'h0020_0000, 32'h0001_1111, 6'd0, 6'd0, 1'b0, 1'b0);
      got_addr.delete(); got_dat.delete();
      b = done_cnt;
      pulse_start(c0);
      repeat (3) @(posedge clock);
      #1;
      vram_wait = 1'b1;
      for (int s = 0; s < 3; s++) begin
         @(negedge clock);
         checks++;
         if (ra_vram_wr !== 1'b1 || ra_vram_addr !== 24'h10_0008 || ra_vram_dout !== 32'h0020_0020) begin
            errors++;
            $display("FAIL stall_hold%0d got wr=%b %h@%h want wr=1 00200020@100008", s, ra_vram_wr, ra_vram_dout, ra_vram_addr);
         end
         @(posedge clock);
         #1;
      end
      vram_wait = 1'b0;
      wait_done(b, 50);
      checks++; if (done_cyc - c0 != 11) begin errors++; $display("FAIL stall_latency got %0d want 11", done_cyc - c0); end
      checks++; if (got_dat.size() != 6) begin errors++; $display("FAIL stall_count got %0d want 6", got_dat.size()); end
      for (int i = 0; i < 6 && i < got_dat.size(); i++) begin
         checks++;
         if (got_dat[i] !== exp_d[i] || got_addr[i] !== 24'h10_0000 + 24'(4 * i)) begin
            errors++;
            $display("FAIL stall_word%0d got %h@%h want %h@%h", i, got_dat[i], got_addr[i], exp_d[i], 24'h10_0000 + 24'(4 * i));
         end
      end
      repeat (2) @(posedge clock);
   endtask

   task automatic test_reset_mid;
      int c0, b;
      logic [31:0] exp_d [6];
      exp_d = '{32'h8000_0000, 32'h0020_0000, 32'h0020_0020, 32'h0020_0040, 32'h0020_0060, 32'h0020_0080};
      set_cfg(32'h0010_0000, 32'h0020_0000, 32'h0020_0000, 32'h0001_1111, 6'd0, 6'd0, 1'b0, 1'b0);
      got_addr.delete(); got_dat.delete();
      pulse_start(c0);
      repeat (5) @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (ra_vram_wr !== 1'b0 || ra_vram_addr !== 24'd0 || ra_vram_dout !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL midreset_outputs got wr=%b addr=%h dout=%h busy=%b done=%b want all 0",
                  ra_vram_wr, ra_vram_addr, ra_vram_dout, busy, done);
      end
      @(negedge clock);
      #1;
      reset_n = 1'b1;
      checks++; if (got_dat.size() != 4) begin errors++; $display("FAIL midreset_partial got %0d want 4", got_dat.size()); end
      got_addr.delete(); got_dat.delete();
      b = done_cnt;
      pulse_start(c0);
      wait_done(b, 50);
      checks++; if (done_cyc - c0 != 8) begin errors++; $display("FAIL restart_latency got %0d want 8", done_cyc - c0); end
      checks++; if (got_dat.size() != 6) begin errors++; $display("FAIL restart_count got %0d want 6", got_dat.size()); end
      for (int i = 0; i < 6 && i < got_dat.size(); i++) begin
         checks++;
         if (got_dat[i] !== exp_d[i] || got_addr[i] !== 24'h10_0000 + 24'(4 * i)) begin
            errors++;
            $display("FAIL restart_word%0d got %h@%h want %h@%h", i, got_dat[i], got_addr[i], exp_d[i], 24'h10_0000 + 24'(4 * i));
         end
      end
      repeat (2) @(posedge clock);
   endtask

   task automatic test_wrap_restart_ignored;
      int c0, b;
      set_cfg(32'h0000_0400, 32'h00FF_FFF0, 32'h0000_0000, 32'h0000_0001, 6'd1, 6'd0, 1'b0, 1'b0);
      got_addr.delete(); got_dat.delete();
      b = done_cnt;
      pulse_start(c0);
      repeat (3) @(posedge clock);
      #1;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      wait_done(b, 50);
      checks++; if (done_cyc - c0 != 12) begin errors++; $display("FAIL wrap_latency got %0d want 12", done_cyc - c0); end
      checks++; if (got_dat.size() != 10) begin errors++; $display("FAIL wrap_count got %0d want 10", got_dat.size()); end
      if (got_dat.size() >= 10) begin
         checks++; if (got_dat[1] !== 32'h00FF_FFF0) begin errors++; $display("FAIL wrap_o0 got %h want 00fffff0", got_dat[1]); end
         checks++; if (got_dat[5] !== 32'h8000_0004) begin errors++; $display("FAIL wrap_ctrl1 got %h want 80000004", got_dat[5]); end
         checks++; if (got_dat[6] !== 32'h0000_0010) begin errors++; $display("FAIL wrap_o1 got %h want 00000010", got_dat[6]); end
      end
      repeat (20) @(posedge clock);
      #1;
      checks++; if (got_dat.size() != 10) begin errors++; $display("FAIL wrap_no_rerun got %0d want 10", got_dat.size()); end
      checks++; if (done_cnt - b != 1) begin errors++; $display("FAIL wrap_single_done got %0d want 1", done_cnt - b); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_idle_busy got %b want 0", busy); end
   endtask

   initial begin
      start     = 1'b0;
      vram_wait = 1'b0;
      set_cfg(32'h0, 32'h0, 32'h0, 32'h0, 6'd0, 6'd0, 1'b0, 1'b0);
      test_reset();
      test_single_v2();
      test_grid_v1();
      test_ctrl_bits();
      test_stall();
      test_reset_mid();
      test_wrap_restart_ignored();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
